// File: rtl/ospi_flash_pkg.sv
// Shared encodings for the OSPI flash-array model: command opcodes, FSM states
// and status-word bit positions.
package ospi_flash_pkg;

    typedef enum logic [2:0] {
        OP_NOP          = 3'd0,
        OP_READ         = 3'd1,
        OP_PROGRAM      = 3'd2,
        OP_SECTOR_ERASE = 3'd3,
        OP_CHIP_ERASE   = 3'd4,
        OP_WREN         = 3'd5,
        OP_WRDI         = 3'd6
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PROG  = 2'd1,
        S_ERASE = 2'd2
    } state_e;

    localparam int ST_BUSY = 0;
    localparam int ST_WEL  = 1;
    localparam int ST_ERR  = 2;

endpackage

// File: rtl/ospi_flash_array.sv
// Behavioural NOR flash array: write-enable latch, multi-cycle program/erase, status word.
// Define OSPI_FLASH_WP_EN to add the active-low write-protect input wp_n.
module ospi_flash_array
    import ospi_flash_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int SECTOR_W    = 4,
    parameter int PROG_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              OSPI_CS,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              busy,
`ifdef OSPI_FLASH_WP_EN
    input  logic              wp_n,
`endif
    output logic [2:0]        status
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int PCW   = (PROG_CYCLES > 1) ? $clog2(PROG_CYCLES) : 1;
    localparam logic [ADDR_W-1:0] SECTOR_MASK = ADDR_W'((1 << SECTOR_W) - 1);

    // Array content survives reset; it only starts out erased.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '1};

    state_e            state_q, state_d;
    logic              wel_q, wel_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic [ADDR_W-1:0] op_addr_q, op_addr_d;
    logic [ADDR_W-1:0] erase_end_q, erase_end_d;
    logic [DATA_W-1:0] op_data_q, op_data_d;
    logic [PCW-1:0]    prog_cnt_q, prog_cnt_d;

    logic              accept;
    logic              wr_allowed;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign accept = cmd_valid && !busy_q && !OSPI_CS;

`ifdef OSPI_FLASH_WP_EN
    assign wr_allowed = wel_q && wp_n;
`else
    assign wr_allowed = wel_q;
`endif

    always_comb begin
        state_d     = state_q;
        wel_d       = wel_q;
        err_d       = err_q;
        rd_valid_d  = 1'b0;
        data_out_d  = data_out_q;
        op_addr_d   = op_addr_q;
        erase_end_d = erase_end_q;
        op_data_d   = op_data_q;
        prog_cnt_d  = prog_cnt_q;
        mem_we      = 1'b0;
        mem_waddr   = op_addr_q;
        mem_wdata   = '1;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_READ: begin
                            data_out_d = mem[address];
                            rd_valid_d = 1'b1;
                        end
                        OP_WREN: begin
                            wel_d = 1'b1;
                            err_d = 1'b0;
                        end
                        OP_WRDI: wel_d = 1'b0;
                        OP_PROGRAM: begin
                            if (wr_allowed) begin
                                state_d    = S_PROG;
                                op_addr_d  = address;
                                op_data_d  = data_in;
                                prog_cnt_d = PCW'(PROG_CYCLES - 1);
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_SECTOR_ERASE: begin
                            if (wr_allowed) begin
                                state_d     = S_ERASE;
                                op_addr_d   = address & ~SECTOR_MASK;
                                erase_end_d = address | SECTOR_MASK;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_CHIP_ERASE: begin
                            if (wr_allowed) begin
                                state_d     = S_ERASE;
                                op_addr_d   = '0;
                                erase_end_d = '1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_PROG: begin
                // NOR programming can only clear bits.
                if (prog_cnt_q == '0) begin
                    mem_we    = 1'b1;
                    mem_wdata = mem[op_addr_q] & op_data_q;
                    wel_d     = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    prog_cnt_d = prog_cnt_q - 1'b1;
                end
            end
            S_ERASE: begin
                // Stop on the last word instead of letting the pointer wrap.
                mem_we = 1'b1;
                if (op_addr_q == erase_end_q) begin
                    wel_d   = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    op_addr_d = op_addr_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            wel_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            data_out_q <= '1;
        end else begin
            state_q    <= state_d;
            wel_q      <= wel_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            rd_valid_q <= rd_valid_d;
            data_out_q <= data_out_d;
        end
    end

    always_ff @(posedge clk) begin
        op_addr_q   <= op_addr_d;
        erase_end_q <= erase_end_d;
        op_data_q   <= op_data_d;
        prog_cnt_q  <= prog_cnt_d;
    end

    // Writes are gated by state, so an asynchronous reset stops them immediately.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        status          = '0;
        status[ST_BUSY] = busy_q;
        status[ST_WEL]  = wel_q;
        status[ST_ERR]  = err_q;
    end

    assign cmd_ready = !busy_q;
    assign busy      = busy_q;
    assign rd_valid  = rd_valid_q;
    assign data_out  = data_out_q;

endmodule

// File: tb/tb_ospi_flash_array.sv
// Self-checking bench for ospi_flash_array: vector table, corner sequences, random vs model.
// Also builds with OSPI_FLASH_WP_EN defined, adding the write-protect checks.
module tb_ospi_flash_array;

    localparam int DATA_W      = 8;
    localparam int ADDR_W      = 8;
    localparam int SECTOR_W    = 4;
    localparam int PROG_CYCLES = 4;
    localparam int DEPTH       = 1 << ADDR_W;
    localparam int SECTOR      = 1 << SECTOR_W;

    localparam logic [2:0] OPC_NOP  = 3'd0;
    localparam logic [2:0] OPC_READ = 3'd1;
    localparam logic [2:0] OPC_PROG = 3'd2;
    localparam logic [2:0] OPC_SE   = 3'd3;
    localparam logic [2:0] OPC_CE   = 3'd4;
    localparam logic [2:0] OPC_WREN = 3'd5;
    localparam logic [2:0] OPC_WRDI = 3'd6;
    localparam logic [2:0] OPC_RSV  = 3'd7;

    logic              clk;
    logic              reset_n;
    logic              OSPI_CS;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              busy;
    logic              wp_n;
    logic [2:0]        status;

    int n_checks = 0;
    int n_err    = 0;

    logic [DATA_W-1:0] mm [DEPTH];
    logic              m_wel;
    logic              m_err;

    ospi_flash_array #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SECTOR_W(SECTOR_W), .PROG_CYCLES(PROG_CYCLES)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .OSPI_CS(OSPI_CS),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .address(address),
        .data_in(data_in),
        .data_out(data_out),
        .rd_valid(rd_valid),
        .busy(busy),
`ifdef OSPI_FLASH_WP_EN
        .wp_n(wp_n),
`endif
        .status(status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: applies one accepted command's full effect at once.
    task automatic model_apply(input logic [2:0] op, input logic [7:0] addr, input logic [7:0] data,
                               output int eb, output logic [7:0] er);
        int base;
        eb = 0;
        er = mm[addr];
        case (op)
            OPC_PROG: begin
                if (m_wel && wp_n) begin
                    mm[addr] = mm[addr] & data;
                    m_wel = 1'b0;
                    eb = PROG_CYCLES;
                end else m_err = 1'b1;
            end
            OPC_SE: begin
                if (m_wel && wp_n) begin
                    base = (int'(addr) / SECTOR) * SECTOR;
                    for (int i = 0; i < SECTOR; i++) mm[base + i] = '1;
                    m_wel = 1'b0;
                    eb = SECTOR;
                end else m_err = 1'b1;
            end
            OPC_CE: begin
                if (m_wel && wp_n) begin
                    for (int i = 0; i < DEPTH; i++) mm[i] = '1;
                    m_wel = 1'b0;
                    eb = DEPTH;
                end else m_err = 1'b1;
            end
            OPC_WREN: begin
                m_wel = 1'b1;
                m_err = 1'b0;
            end
            OPC_WRDI: m_wel = 1'b0;
            default: ;
        endcase
    endtask

    // Present one command for one edge, then count cycles until busy drops.
    task automatic run_cmd(input logic [2:0] op, input logic [7:0] addr, input logic [7:0] data,
                           output int bc, output logic rv, output logic [7:0] rd);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        address   = addr;
        data_in   = data;
        @(posedge clk);
        #1;
        rv = rd_valid;
        rd = data_out;
        cmd_valid = 1'b0;
        bc = 0;
        while (busy && bc < 1000) begin
            bc++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [7:0] addr, input logic [7:0] data);
        int eb, bc;
        logic [7:0] er, rd;
        logic rv;
        model_apply(op, addr, data, eb, er);
        run_cmd(op, addr, data, bc, rv, rd);
        check("busy_cycles", bc, eb);
        check("status", status, {m_err, m_wel, 1'b0});
        check("rd_valid", rv, op == OPC_READ);
        if (op == OPC_READ) check("read_data", rd, er);
    endtask

    typedef struct {
        logic [2:0] op;
        logic [7:0] addr;
        logic [7:0] data;
        int         bcyc;
        logic [2:0] st;
        logic [7:0] rd;
    } vec_t;

    vec_t vt[24];

    initial begin
        int eb, bc, cnt;
        logic [7:0] er, rd;
        logic rv;

        reset_n = 1'b0; OSPI_CS = 1'b0; cmd_valid = 1'b0; cmd_op = OPC_NOP;
        address = '0; data_in = '0; wp_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) mm[i] = '1;
        m_wel = 1'b0; m_err = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_data_out", data_out, 8'hFF);
        check("reset_rd_valid", rd_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_status", status, 0);
        check("reset_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;

        vt[0]  = '{OPC_READ, 8'h10, 8'h00, 0,  3'b000, 8'hFF};
        vt[1]  = '{OPC_WREN, 8'h00, 8'h00, 0,  3'b010, 8'h00};
        vt[2]  = '{OPC_PROG, 8'h10, 8'hA5, 4,  3'b000, 8'h00};
        vt[3]  = '{OPC_READ, 8'h10, 8'h00, 0,  3'b000, 8'hA5};
        vt[4]  = '{OPC_WREN, 8'h00, 8'h00, 0,  3'b010, 8'h00};
        vt[5]  = '{OPC_PROG, 8'h10, 8'h5A, 4,  3'b000, 8'h00};
        vt[6]  = '{OPC_READ, 8'h10, 8'h00, 0,  3'b000, 8'h00};
        vt[7]  = '{OPC_PROG, 8'h11, 8'h00, 0,  3'b100, 8'h00};
        vt[8]  = '{OPC_READ, 8'h11, 8'h00, 0,  3'b100, 8'hFF};
        vt[9]  = '{OPC_WREN, 8'h00, 8'h00, 0,  3'b010, 8'h00};
        vt[10] = '{OPC_PROG, 8'h13, 8'h00, 4,  3'b000, 8'h00};
        vt[11] = '{OPC_WREN, 8'h00, 8'h00, 0,  3'b010, 8'h00};
        vt[12] = '{OPC_PROG, 8'h20, 8'h00, 4,  3'b000, 8'h00};
        vt[13] = '{OPC_WREN, 8'h00, 8'h00, 0,  3'b010, 8'h00};
        vt[14] = '{OPC_SE,   8'h17, 8'h00, 16, 3'b000, 8'h00};
        vt[15] = '{OPC_READ, 8'h13, 8'h00, 0,  3'b000, 8'hFF};
        vt[16] = '{OPC_READ, 8'h20, 8'h00, 0,  3'b000, 8'h00};
        vt[17] = '{OPC_READ, 8'h10, 8'h00, 0,  3'b000, 8'hFF};
        vt[18] = '{OPC_WREN, 8'h00, 8'h00, 0,  3'b010, 8'h00};
        vt[19] = '{OPC_WRDI, 8'h00, 8'h00, 0,  3'b000, 8'h00};
        vt[20] = '{OPC_SE,   8'h17, 8'h00, 0,  3'b100, 8'h00};
        vt[21] = '{OPC_RSV,  8'h10, 8'h00, 0,  3'b100, 8'h00};
        vt[22] = '{OPC_CE,   8'h00, 8'h00, 0,  3'b100, 8'h00};
        vt[23] = '{OPC_WREN, 8'h00, 8'h00, 0,  3'b010, 8'h00};

        for (int i = 0; i < 24; i++) begin
            model_apply(vt[i].op, vt[i].addr, vt[i].data, eb, er);
            run_cmd(vt[i].op, vt[i].addr, vt[i].data, bc, rv, rd);
            check($sformatf("vec%0d_busy", i), bc, vt[i].bcyc);
            check($sformatf("vec%0d_status", i), status, vt[i].st);
            check($sformatf("vec%0d_rd_valid", i), rv, vt[i].op == OPC_READ);
            if (vt[i].op == OPC_READ) begin
                check($sformatf("vec%0d_data", i), rd, vt[i].rd);
                @(posedge clk);
                #1;
                check($sformatf("vec%0d_rd_pulse", i), rd_valid, 0);
            end
        end

        // Held command: READ kept valid through a program is taken one edge after busy falls.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OPC_PROG; address = 8'h60; data_in = 8'hC3;
        @(posedge clk);
        #1;
        model_apply(OPC_PROG, 8'h60, 8'hC3, eb, er);
        check("held_busy", busy, 1);
        check("held_ready_low", cmd_ready, 0);
        cmd_op = OPC_READ;
        cnt = 0;
        while (!rd_valid && cnt < 50) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        cmd_valid = 1'b0;
        check("held_accept_edge", cnt, PROG_CYCLES + 1);
        check("held_read_data", data_out, 8'hC3);

        // Chip select high blocks acceptance.
        OSPI_CS = 1'b1;
        run_cmd(OPC_READ, 8'h60, 8'h00, bc, rv, rd);
        check("cs_read_rd_valid", rv, 0);
        run_cmd(OPC_WREN, 8'h00, 8'h00, bc, rv, rd);
        check("cs_wren_status", status, {m_err, m_wel, 1'b0});
        OSPI_CS = 1'b0;

        // Chip select rising mid-program does not abort it.
        issue(OPC_WREN, 8'h00, 8'h00);
        model_apply(OPC_PROG, 8'h31, 8'h0F, eb, er);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OPC_PROG; address = 8'h31; data_in = 8'h0F;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        OSPI_CS = 1'b1;
        bc = 0;
        while (busy && bc < 1000) begin
            bc++;
            @(posedge clk);
            #1;
        end
        OSPI_CS = 1'b0;
        check("cs_prog_busy", bc, PROG_CYCLES);
        run_cmd(OPC_READ, 8'h31, 8'h00, bc, rv, rd);
        check("cs_prog_data", rd, 8'h0F);

        // Reset during program leaves the word untouched.
        issue(OPC_WREN, 8'h00, 8'h00);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OPC_PROG; address = 8'h30; data_in = 8'h00;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("prog_rst_busy", busy, 0);
        check("prog_rst_status", status, 0);
        @(negedge clk);
        reset_n = 1'b1;
        m_wel = 1'b0; m_err = 1'b0;
        run_cmd(OPC_READ, 8'h30, 8'h00, bc, rv, rd);
        check("prog_rst_data", rd, 8'hFF);

        // Reset five cycles into a chip erase.
        issue(OPC_WREN, 8'h00, 8'h00);
        issue(OPC_PROG, 8'h02, 8'h00);
        issue(OPC_WREN, 8'h00, 8'h00);
        issue(OPC_PROG, 8'h40, 8'h00);
        issue(OPC_WREN, 8'h00, 8'h00);
        issue(OPC_PROG, 8'h80, 8'h3C);
        issue(OPC_WREN, 8'h00, 8'h00);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OPC_CE; address = 8'h00;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("ce_busy", busy, 1);
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("ce_rst_busy", busy, 0);
        check("ce_rst_status", status, 0);
        check("ce_rst_data_out", data_out, 8'hFF);
        check("ce_rst_rd_valid", rd_valid, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) mm[i] = '1;
        m_wel = 1'b0; m_err = 1'b0;
        for (int i = 0; i < 5; i++) begin
            run_cmd(OPC_READ, 8'(i), 8'h00, bc, rv, rd);
            check($sformatf("ce_rst_erased_%0d", i), rd, 8'hFF);
        end
        run_cmd(OPC_READ, 8'h40, 8'h00, bc, rv, rd);
        check("ce_rst_untouched_40", rd, 8'h00);
        run_cmd(OPC_READ, 8'h80, 8'h00, bc, rv, rd);
        check("ce_rst_untouched_80", rd, 8'h3C);

`ifdef OSPI_FLASH_WP_EN
        // Write protect rejects program and erase but keeps wel.
        wp_n = 1'b0;
        issue(OPC_WREN, 8'h00, 8'h00);
        issue(OPC_PROG, 8'h50, 8'h00);
        check("wp_prog_status", status, 3'b110);
        issue(OPC_SE, 8'h50, 8'h00);
        check("wp_se_status", status, 3'b110);
        run_cmd(OPC_READ, 8'h50, 8'h00, bc, rv, rd);
        check("wp_prog_data", rd, 8'hFF);
        wp_n = 1'b1;
`endif

        // Randomized commands against the reference model.
        for (int n = 0; n < 200; n++) begin
            int r;
            logic [2:0] op;
            r = int'($urandom_range(0, 99));
            if (r < 30)      op = OPC_READ;
            else if (r < 50) op = OPC_PROG;
            else if (r < 55) op = OPC_SE;
            else if (r < 56) op = OPC_CE;
            else if (r < 76) op = OPC_WREN;
            else if (r < 83) op = OPC_WRDI;
            else if (r < 91) op = OPC_NOP;
            else             op = OPC_RSV;
`ifdef OSPI_FLASH_WP_EN
            wp_n = ($urandom_range(0, 3) != 0);
`endif
            issue(op, 8'($urandom_range(0, DEPTH - 1)), 8'($urandom_range(0, 255)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
